// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified memory port arbiter.
package mem_arb_pkg;

   localparam int unsigned ADDR_W_DEF     = 32;
   localparam int unsigned DATA_W_DEF     = 32;
   localparam int unsigned MEM_LAT_DEF    = 2;
   localparam int unsigned STARVE_MAX_DEF = 3;

   typedef enum logic {IDLE, WAIT} state_e;
   typedef enum logic {OWN_IF, OWN_LS} owner_e;

endpackage

// File: rtl/mem_arb_prio.sv
// Picks the memory-port owner: load/store first, fetch when alone or starved.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF,
   parameter int unsigned SW         = 2
) (
   input  logic          if_req,
   input  logic          ls_req,
   input  logic [SW-1:0] starve_cnt,
   output owner_e        owner
);

   always_comb begin
      owner = OWN_LS;
      if (if_req && (!ls_req || (starve_cnt == SW'(STARVE_MAX)))) begin
         owner = OWN_IF;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between fetch and load/store, one
// transaction in flight, with registered per-requester responses.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = ADDR_W_DEF,
   parameter int unsigned DATA_W     = DATA_W_DEF,
   parameter int unsigned MEM_LAT    = MEM_LAT_DEF,
   parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [DATA_W-1:0]   if_rdata,
   input  logic                ls_req,
   input  logic                ls_we,
   input  logic [DATA_W/8-1:0] ls_be,
   input  logic [ADDR_W-1:0]   ls_addr,
   input  logic [DATA_W-1:0]   ls_wdata,
   output logic                ls_gnt,
   output logic                ls_rvalid,
   output logic [DATA_W-1:0]   ls_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [DATA_W/8-1:0] mem_be,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata
);

   localparam int unsigned CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int unsigned SW    = $clog2(STARVE_MAX + 1);

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   owner_e              win_c;
   logic                we_q, we_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [SW-1:0]       starve_q, starve_d;
   logic                if_rvalid_q, if_rvalid_d;
   logic                ls_rvalid_q, ls_rvalid_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   ls_rdata_q, ls_rdata_d;
   logic                grant_c;

   mem_arb_prio #(
      .STARVE_MAX (STARVE_MAX),
      .SW         (SW)
   ) u_prio (
      .if_req     (if_req),
      .ls_req     (ls_req),
      .starve_cnt (starve_q),
      .owner      (win_c)
   );

   // Grant and memory strobe are same-cycle from req; suppressed in WAIT and reset.
   always_comb begin
      grant_c   = rst && (state_q == IDLE) && (if_req || ls_req);
      if_gnt    = grant_c && (win_c == OWN_IF);
      ls_gnt    = grant_c && (win_c == OWN_LS);
      mem_en    = grant_c;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      if (if_gnt) begin
         mem_be   = '1;
         mem_addr = if_addr;
      end else if (ls_gnt) begin
         mem_we    = ls_we;
         mem_be    = ls_be;
         mem_addr  = ls_addr;
         mem_wdata = ls_wdata;
      end
   end

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      cnt_d       = cnt_q;
      starve_d    = starve_q;
      if_rvalid_d = 1'b0;
      ls_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      ls_rdata_d  = ls_rdata_q;
      case (state_q)
         IDLE: begin
            if (grant_c) begin
               state_d = WAIT;
               owner_d = win_c;
               we_d    = (win_c == OWN_LS) && ls_we;
               cnt_d   = CNT_W'(MEM_LAT - 1);
               // Starvation only accrues while fetch is actually waiting.
               if ((win_c == OWN_IF) || !if_req) begin
                  starve_d = '0;
               end else if (starve_q != SW'(STARVE_MAX)) begin
                  starve_d = starve_q + SW'(1);
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = IDLE;
               if (owner_q == OWN_IF) begin
                  if_rdata_d  = mem_rdata;
                  if_rvalid_d = 1'b1;
               end else begin
                  ls_rdata_d  = we_q ? '0 : mem_rdata;
                  ls_rvalid_d = 1'b1;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         owner_q     <= OWN_IF;
         we_q        <= 1'b0;
         cnt_q       <= '0;
         starve_q    <= '0;
         if_rvalid_q <= 1'b0;
         ls_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         ls_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         cnt_q       <= cnt_d;
         starve_q    <= starve_d;
         if_rvalid_q <= if_rvalid_d;
         ls_rvalid_q <= ls_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         ls_rdata_q  <= ls_rdata_d;
      end
   end

   assign if_rvalid = if_rvalid_q;
   assign ls_rvalid = ls_rvalid_q;
   assign if_rdata  = if_rdata_q;
   assign ls_rdata  = ls_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: one arbiter at MEM_LAT=2 and one at MEM_LAT=1, each on a
// small synchronous memory model with exact read latency.
module tb_mem_port_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   logic        a_if_req, a_if_gnt, a_if_rvalid;
   logic [31:0] a_if_addr, a_if_rdata;
   logic        a_ls_req, a_ls_we, a_ls_gnt, a_ls_rvalid;
   logic [3:0]  a_ls_be, a_mem_be;
   logic [31:0] a_ls_addr, a_ls_wdata, a_ls_rdata;
   logic        a_mem_en, a_mem_we;
   logic [31:0] a_mem_addr, a_mem_wdata, a_mem_rdata;

   logic        b_if_req, b_if_gnt, b_if_rvalid;
   logic [31:0] b_if_addr, b_if_rdata;
   logic        b_ls_req, b_ls_we, b_ls_gnt, b_ls_rvalid;
   logic [3:0]  b_ls_be, b_mem_be;
   logic [31:0] b_ls_addr, b_ls_wdata, b_ls_rdata;
   logic        b_mem_en, b_mem_we;
   logic [31:0] b_mem_addr, b_mem_wdata, b_mem_rdata;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(2), .STARVE_MAX(3)) u_dut_a (
      .clk(clk), .rst(rst),
      .if_req(a_if_req), .if_addr(a_if_addr), .if_gnt(a_if_gnt),
      .if_rvalid(a_if_rvalid), .if_rdata(a_if_rdata),
      .ls_req(a_ls_req), .ls_we(a_ls_we), .ls_be(a_ls_be), .ls_addr(a_ls_addr),
      .ls_wdata(a_ls_wdata), .ls_gnt(a_ls_gnt), .ls_rvalid(a_ls_rvalid), .ls_rdata(a_ls_rdata),
      .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_be(a_mem_be), .mem_addr(a_mem_addr),
      .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata)
   );

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .STARVE_MAX(3)) u_dut_b (
      .clk(clk), .rst(rst),
      .if_req(b_if_req), .if_addr(b_if_addr), .if_gnt(b_if_gnt),
      .if_rvalid(b_if_rvalid), .if_rdata(b_if_rdata),
      .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_be(b_ls_be), .ls_addr(b_ls_addr),
      .ls_wdata(b_ls_wdata), .ls_gnt(b_ls_gnt), .ls_rvalid(b_ls_rvalid), .ls_rdata(b_ls_rdata),
      .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_be(b_mem_be), .mem_addr(b_mem_addr),
      .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata)
   );

   // Memory contents: fixed instruction at 0x10, address-derived words elsewhere.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h10) return 32'h0050_0093;
      return {a[15:0] ^ 16'h5A5A, a[15:0]};
   endfunction

   // Read data appears exactly MEM_LAT cycles after mem_en; filler otherwise.
   logic [31:0] a_pipe0, a_pipe1, b_pipe0;
   always @(posedge clk) begin
      a_pipe0 <= a_mem_en ? mem_word(a_mem_addr) : 32'hBAD0_0000;
      a_pipe1 <= a_pipe0;
      b_pipe0 <= b_mem_en ? mem_word(b_mem_addr) : 32'hBAD1_0000;
   end
   assign a_mem_rdata = a_pipe1;
   assign b_mem_rdata = b_pipe0;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // {if_gnt, ls_gnt, if_rvalid, ls_rvalid, mem_en, mem_we}
   function automatic logic [31:0] a_ctrl();
      return {26'd0, a_if_gnt, a_ls_gnt, a_if_rvalid, a_ls_rvalid, a_mem_en, a_mem_we};
   endfunction

   logic        exp_if [5];
   logic [31:0] b_addrs [4];

   initial begin
      exp_if  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
      b_addrs = '{32'h40, 32'h44, 32'h48, 32'h4C};
      rst = 1'b0;
      a_if_req = 1'b1; a_if_addr = 32'h0;
      a_ls_req = 1'b0; a_ls_we = 1'b0; a_ls_be = 4'h0; a_ls_addr = 32'h0; a_ls_wdata = 32'h0;
      b_if_req = 1'b0; b_if_addr = 32'h0;
      b_ls_req = 1'b0; b_ls_we = 1'b0; b_ls_be = 4'hF; b_ls_addr = 32'h0; b_ls_wdata = 32'h0;

      // Reset: no grant even with a request pending
      repeat (2) begin
         @(negedge clk); #1;
         check_eq("rst_ctrl", a_ctrl(), 32'h0);
      end
      @(negedge clk);
      a_if_req = 1'b0;
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         #1;
         check_eq("idle_ctrl", a_ctrl(), 32'h0);
         check_eq("idle_data", a_if_rdata | a_ls_rdata | a_mem_addr | a_mem_wdata | 32'(a_mem_be), 32'h0);
         @(negedge clk);
      end

      // Single fetch at 0x10
      a_if_req = 1'b1; a_if_addr = 32'h10; #1;
      check_eq("fetch_gnt", a_ctrl(), 32'b100010);
      check_eq("fetch_addr", a_mem_addr, 32'h10);
      check_eq("fetch_be", 32'(a_mem_be), 32'hF);
      @(negedge clk); a_if_req = 1'b0; #1;
      check_eq("fetch_t1", a_ctrl(), 32'h0);
      @(negedge clk); #1;
      check_eq("fetch_t2", a_ctrl(), 32'h0);
      @(negedge clk); #1;
      check_eq("fetch_rvalid", a_ctrl(), 32'b001000);
      check_eq("fetch_rdata", a_if_rdata, 32'h0050_0093);
      @(negedge clk); #1;
      check_eq("fetch_t4", a_ctrl(), 32'h0);
      check_eq("fetch_hold", a_if_rdata, 32'h0050_0093);

      // Load at 0x200
      @(negedge clk);
      a_ls_req = 1'b1; a_ls_we = 1'b0; a_ls_be = 4'hF; a_ls_addr = 32'h200; #1;
      check_eq("load_gnt", a_ctrl(), 32'b010010);
      check_eq("load_addr", a_mem_addr, 32'h200);
      @(negedge clk); a_ls_req = 1'b0;
      @(negedge clk);
      @(negedge clk); #1;
      check_eq("load_rvalid", a_ctrl(), 32'b000100);
      check_eq("load_rdata", a_ls_rdata, mem_word(32'h200));

      // Store: partial byte enables, completion returns zero data
      @(negedge clk);
      a_ls_req = 1'b1; a_ls_we = 1'b1; a_ls_be = 4'b0011;
      a_ls_addr = 32'h100; a_ls_wdata = 32'hDEAD_BEEF; #1;
      check_eq("store_gnt", a_ctrl(), 32'b010011);
      check_eq("store_be", 32'(a_mem_be), 32'h3);
      check_eq("store_addr", a_mem_addr, 32'h100);
      check_eq("store_wdata", a_mem_wdata, 32'hDEAD_BEEF);
      @(negedge clk); a_ls_req = 1'b0; a_ls_we = 1'b0; #1;
      check_eq("store_t1", a_ctrl(), 32'h0);
      @(negedge clk);
      @(negedge clk); #1;
      check_eq("store_rvalid", a_ctrl(), 32'b000100);
      check_eq("store_rdata", a_ls_rdata, 32'h0);

      // Contention: both held, expect LS LS LS IF LS every 3 cycles
      for (int g = 0; g < 5; g++) begin
         @(negedge clk);
         if (g == 0) begin
            a_if_req = 1'b1; a_if_addr = 32'h20;
            a_ls_req = 1'b1; a_ls_we = 1'b0; a_ls_be = 4'hF; a_ls_addr = 32'h300;
         end
         #1;
         check_eq("cont_gnt", {30'd0, a_if_gnt, a_ls_gnt}, exp_if[g] ? 32'h2 : 32'h1);
         check_eq("cont_addr", a_mem_addr, exp_if[g] ? 32'h20 : 32'h300);
         if (g > 0) begin
            check_eq("cont_rvalid", {30'd0, a_if_rvalid, a_ls_rvalid}, exp_if[g-1] ? 32'h2 : 32'h1);
            if (exp_if[g-1]) check_eq("cont_if_rdata", a_if_rdata, mem_word(32'h20));
            else             check_eq("cont_ls_rdata", a_ls_rdata, mem_word(32'h300));
         end
         repeat (2) begin
            @(negedge clk); #1;
            check_eq("cont_gap", {30'd0, a_if_gnt, a_ls_gnt}, 32'h0);
         end
      end
      @(negedge clk); a_if_req = 1'b0; a_ls_req = 1'b0; #1;
      check_eq("cont_last", a_ctrl(), 32'b000100);
      check_eq("cont_last_rdata", a_ls_rdata, mem_word(32'h300));

      // Reset one cycle after an LS grant drops the load
      @(negedge clk);
      a_ls_req = 1'b1; a_ls_addr = 32'h400; #1;
      check_eq("rmid_gnt", a_ctrl(), 32'b010010);
      @(negedge clk);
      a_ls_req = 1'b0; a_if_req = 1'b1; a_if_addr = 32'h30; rst = 1'b0; #1;
      check_eq("rmid_ctrl", a_ctrl(), 32'h0);
      check_eq("rmid_ls_rdata", a_ls_rdata, 32'h0);
      @(negedge clk); rst = 1'b1; #1;
      check_eq("rmid_if_gnt", a_ctrl(), 32'b100010);
      check_eq("rmid_if_addr", a_mem_addr, 32'h30);
      @(negedge clk); a_if_req = 1'b0; #1;
      check_eq("rmid_t3", a_ctrl(), 32'h0);
      @(negedge clk); #1;
      check_eq("rmid_no_ls_rvalid", a_ctrl(), 32'h0);
      @(negedge clk); #1;
      check_eq("rmid_if_rvalid", a_ctrl(), 32'b001000);
      check_eq("rmid_if_rdata", a_if_rdata, mem_word(32'h30));

      // MEM_LAT=1 back-to-back loads: a grant every 2 cycles
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         b_ls_req = 1'b1; b_ls_addr = b_addrs[i]; #1;
         check_eq("b2b_gnt", {30'd0, b_ls_gnt, b_mem_en}, 32'h3);
         check_eq("b2b_addr", b_mem_addr, b_addrs[i]);
         if (i > 0) begin
            check_eq("b2b_rvalid", 32'(b_ls_rvalid), 32'h1);
            check_eq("b2b_rdata", b_ls_rdata, mem_word(b_addrs[i-1]));
         end
         @(negedge clk); #1;
         check_eq("b2b_gap", {30'd0, b_ls_gnt, b_ls_rvalid}, 32'h0);
      end
      @(negedge clk); b_ls_req = 1'b0; #1;
      check_eq("b2b_last_rvalid", {30'd0, b_ls_gnt, b_ls_rvalid}, 32'h1);
      check_eq("b2b_last_rdata", b_ls_rdata, mem_word(32'h4C));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
